// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-channel round-robin select arbiter.
package mux4_arb_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request starting at ptr,
// searching upwards and wrapping 3 -> 0.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Walk the search order from lowest priority to highest so the last hit wins.
  always_comb begin
    found = |req;
    idx   = ptr;
    cand  = ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_sel_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 mux, with a
// per-grant hold limit so no channel can own the mux indefinitely.
module mux4_sel_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_CH-1:0]  req,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  gnt,
  output logic             gnt_valid
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_CH-1:0]   gnt_q, gnt_d;
  logic              gnt_valid_q, gnt_valid_d;

  logic [SEL_W-1:0]  pick_ptr;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;
  logic              rel_grant;

  // During a grant the search starts just past the current owner, which makes
  // the owner lowest priority for the handover; when idle it starts at ptr.
  assign pick_ptr = (state_q == GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state logic: start, hold, release and back-to-back handover of grants.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    rel_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        hold_cnt_d  = '0;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        if (en && pick_found) begin
          state_d     = GRANT;
          sel_d       = pick_idx;
          gnt_d       = N_CH'(1) << pick_idx;
          gnt_valid_d = 1'b1;
        end
      end
      GRANT: begin
        rel_grant = !req[sel_q] || (hold_cnt_q == HOLD_LAST);
        if (rel_grant) begin
          ptr_d      = sel_q + SEL_W'(1);
          hold_cnt_d = '0;
          if (en && pick_found) begin
            sel_d       = pick_idx;
            gnt_d       = N_CH'(1) << pick_idx;
            gnt_valid_d = 1'b1;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  // State, pointer, hold counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Self-checking bench for mux4_sel_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_mux4_sel_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       gnt_valid;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  // Behavioural model: who owns the mux, for how many cycles, and where the
  // round-robin search starts next.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  mux4_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] q);
    rst = r;
    en  = e;
    req = q;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_sel   = 0;
    end else if (m_owner >= 0 && req[m_owner] && m_held < MAX_HOLD) begin
      m_held = m_held + 1;
    end else begin
      if (m_owner >= 0) m_ptr = (m_owner + 1) % 4;
      m_owner = -1;
      m_held  = 0;
      if (en) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_sel   = m_owner;
            m_held  = 1;
          end
        end
      end
    end
  end

  // Compare the DUT against the model on every falling edge once running.
  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("model_gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
      checkOutput("model_sel", int'(sel), m_sel);
      checkOutput("model_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
      checkOutput("gnt_onehot0", int'($onehot0(gnt)), 1);
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [3:0] flip;
    logic [3:0] cur_req;
    logic       r_rnd;
    logic       e_rnd;

    rst = 1'b1;
    en  = 1'b1;
    req = 4'b1111;
    @(posedge clk);
    cmp_on = 1'b1;
    @(negedge clk);

    // Reset held with all requests present.
    applyStimulus(1'b1, 1'b1, 4'b1111);
    checkOutput("reset_gnt", int'(gnt), 0);
    checkOutput("reset_valid", int'(gnt_valid), 0);
    checkOutput("reset_sel", int'(sel), 0);

    // First grant after reset goes to channel 0.
    applyStimulus(1'b0, 1'b1, 4'b1111);
    checkOutput("first_gnt", int'(gnt), 4'b0001);
    checkOutput("first_sel", int'(sel), 0);

    // Fairness: 8 cycles per channel, order 0,1,2,3,0, no gaps.
    for (int k = 1; k < 40; k++) begin
      applyStimulus(1'b0, 1'b1, 4'b1111);
      checkOutput("fair_gnt", int'(gnt), 1 << ((k / 8) % 4));
      checkOutput("fair_valid", int'(gnt_valid), 1);
    end

    // Early release of channel 2, then channel 3 is highest priority.
    applyStimulus(1'b1, 1'b1, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 4'b0100);
      checkOutput("early_gnt", int'(gnt), 4'b0100);
    end
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("early_release", int'(gnt), 4'b0000);
    checkOutput("early_release_sel", int'(sel), 2);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    checkOutput("ptr3_gnt", int'(gnt), 4'b1000);
    checkOutput("ptr3_sel", int'(sel), 3);

    // Enable low blocks grants; dropping it mid-grant lets the grant finish.
    applyStimulus(1'b1, 1'b0, 4'b0011);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 4'b0011);
      checkOutput("en_off_gnt", int'(gnt), 0);
    end
    applyStimulus(1'b0, 1'b1, 4'b0010);
    checkOutput("en_ch1_gnt", int'(gnt), 4'b0010);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 4'b0011);
      checkOutput("en_drop_hold", int'(gnt), 4'b0010);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 4'b0001);
      checkOutput("en_drop_idle", int'(gnt), 0);
    end

    // Reset in the middle of a channel 2 grant.
    applyStimulus(1'b1, 1'b1, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 4'b0100);
      checkOutput("mid_gnt", int'(gnt), 4'b0100);
    end
    applyStimulus(1'b1, 1'b1, 4'b0100);
    checkOutput("mid_rst_gnt", int'(gnt), 0);
    checkOutput("mid_rst_valid", int'(gnt_valid), 0);
    checkOutput("mid_rst_sel", int'(sel), 0);
    applyStimulus(1'b0, 1'b1, 4'b0110);
    checkOutput("post_rst_gnt", int'(gnt), 4'b0010);
    checkOutput("post_rst_sel", int'(sel), 1);

    // Sole requester keeps the mux across repeated timeouts.
    applyStimulus(1'b1, 1'b1, 4'b1000);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b0, 1'b1, 4'b1000);
      checkOutput("sole_gnt", int'(gnt), 4'b1000);
      checkOutput("sole_valid", int'(gnt_valid), 1);
    end

    // Randomized traffic: requests drift bit by bit, occasional en drop and reset.
    cur_req = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      flip    = 4'($urandom) & 4'($urandom);
      cur_req = cur_req ^ flip;
      r_rnd   = ($urandom_range(0, 99) == 0);
      e_rnd   = ($urandom_range(0, 9) != 0);
      applyStimulus(r_rnd, e_rnd, cur_req);
    end

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
